// File: rtl/message_stream_splitter.sv
`default_nettype none
// =============================================================================
// message_stream_splitter - FIFO-buffered fan-out of whole packets to one of
// N_STREAMS outputs, selected by the destination field in each header.
// Revision: 1.0
// =============================================================================
module message_stream_splitter #(
  parameter int N_STREAMS             = 4,
  parameter int LOG_N_STREAMS         = 2,
  parameter int WIDTH                 = 32,
  parameter int BUFFER_LENGTH         = 64,
  parameter int LOG_BUFFER_LENGTH     = 6,
  parameter int MAX_PACKET_LENGTH     = 1024,
  parameter int LOG_MAX_PACKET_LENGTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_nd,
  input  logic [N_STREAMS-1:0] out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [N_STREAMS-1:0] out_nd,
  output logic                 dropped,
  output logic                 error
);

  if (MAX_PACKET_LENGTH > (1 << LOG_MAX_PACKET_LENGTH)) begin : g_len_check
    $error("MAX_PACKET_LENGTH does not fit in the header length field");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [LOG_BUFFER_LENGTH:0] FULL_COUNT = (LOG_BUFFER_LENGTH+1)'(BUFFER_LENGTH);

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]             mem [BUFFER_LENGTH];
  logic [LOG_BUFFER_LENGTH-1:0] wr_ptr;
  logic [LOG_BUFFER_LENGTH-1:0] rd_ptr;
  logic [LOG_BUFFER_LENGTH:0]   count;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         push;
  logic                         pop;
  logic [WIDTH-1:0]             head;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  // Fullness is judged on the start-of-cycle occupancy, so a same-cycle pop
  // never rescues a write into a full buffer.
  assign push       = in_nd && !fifo_full;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      error  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_nd && fifo_full) begin
        error <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Header decode of the FIFO head word
  // ---------------------------------------------------------------------------
  logic [LOG_MAX_PACKET_LENGTH-1:0] hdr_len;
  logic [LOG_N_STREAMS-1:0]         hdr_dest;
  logic [N_STREAMS-1:0]             hdr_onehot;
  logic [N_STREAMS-1:0]             fwd_onehot;
  logic                             hdr_is_header;
  logic                             hdr_routable;
  logic                             hdr_ready;
  logic                             fwd_ready;

  state_t                           state;
  state_t                           state_next;
  logic [LOG_MAX_PACKET_LENGTH-1:0] remaining;
  logic [LOG_MAX_PACKET_LENGTH-1:0] remaining_next;
  logic [LOG_N_STREAMS-1:0]         dest;
  logic [LOG_N_STREAMS-1:0]         dest_next;
  logic                             emit;
  logic                             drop;
  logic [N_STREAMS-1:0]             emit_nd;

  assign hdr_is_header = head[WIDTH-1];
  assign hdr_len       = head[WIDTH-2 -: LOG_MAX_PACKET_LENGTH];
  assign hdr_dest      = head[WIDTH-2-LOG_MAX_PACKET_LENGTH -: LOG_N_STREAMS];
  assign hdr_routable  = (int'(hdr_dest) < N_STREAMS);
  assign hdr_onehot    = N_STREAMS'(1) << hdr_dest;
  assign fwd_onehot    = N_STREAMS'(1) << dest;
  assign hdr_ready     = |(out_ready & hdr_onehot);
  assign fwd_ready     = |(out_ready & fwd_onehot);

  // ---------------------------------------------------------------------------
  // Packet state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      dest      <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      dest      <= dest_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    dest_next      = dest;
    pop            = 1'b0;
    emit           = 1'b0;
    drop           = 1'b0;
    emit_nd        = '0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (!hdr_is_header) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else if (!hdr_routable) begin
            pop  = 1'b1;
            drop = 1'b1;
            if (hdr_len != '0) begin
              remaining_next = hdr_len;
              state_next     = DISCARD;
            end
          end else if (hdr_ready) begin
            pop       = 1'b1;
            emit      = 1'b1;
            emit_nd   = hdr_onehot;
            dest_next = hdr_dest;
            if (hdr_len != '0) begin
              remaining_next = hdr_len;
              state_next     = FORWARD;
            end
          end
        end
      end

      FORWARD: begin
        if (!fifo_empty && fwd_ready) begin
          pop            = 1'b1;
          emit           = 1'b1;
          emit_nd        = fwd_onehot;
          remaining_next = remaining - 1'b1;
          if (remaining == LOG_MAX_PACKET_LENGTH'(1)) begin
            state_next = IDLE;
          end
        end
      end

      DISCARD: begin
        // Payload of an unroutable packet is consumed silently.
        if (!fifo_empty) begin
          pop            = 1'b1;
          remaining_next = remaining - 1'b1;
          if (remaining == LOG_MAX_PACKET_LENGTH'(1)) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_nd   <= '0;
      dropped  <= 1'b0;
    end else begin
      out_nd  <= emit_nd;
      dropped <= drop;
      if (emit) begin
        out_data <= head;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_message_stream_splitter.sv
`default_nettype none
// tb_message_stream_splitter - directed self-checking bench; a second instance
// with three outputs exercises the unroutable-destination path.
module tb_message_stream_splitter;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_nd;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_nd;
  logic        dropped;
  logic        error;

  logic        in_nd3;
  logic [2:0]  out_ready3;
  logic [31:0] out_data3;
  logic [2:0]  out_nd3;
  logic        dropped3;
  logic        error3;

  int checks;
  int fails;

  message_stream_splitter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_nd     (in_nd),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nd    (out_nd),
    .dropped   (dropped),
    .error     (error)
  );

  message_stream_splitter #(.N_STREAMS(3), .LOG_N_STREAMS(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_nd     (in_nd3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .out_nd    (out_nd3),
    .dropped   (dropped3),
    .error     (error3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hdr(input int len, input int dst, input logic [18:0] tag);
    return {1'b1, 10'(len), 2'(dst), tag};
  endfunction

  task automatic test_reset();
    rst_n      = 1'b0;
    in_nd      = 1'b0;
    in_nd3     = 1'b0;
    in_data    = '0;
    out_ready  = 4'b1111;
    out_ready3 = 3'b111;
    repeat (3) @(negedge clk);
    checks++;
    if (out_nd !== 4'b0 || out_data !== 32'h0 || dropped !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out_nd=%b out_data=%h dropped=%b error=%b, required 0000/00000000/0/0",
               out_nd, out_data, dropped, error);
    end
    checks++;
    if (out_nd3 !== 3'b0 || out_data3 !== 32'h0 || dropped3 !== 1'b0 || error3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_n3: out_nd=%b out_data=%h dropped=%b error=%b, required 000/00000000/0/0",
               out_nd3, out_data3, dropped3, error3);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_nd !== 4'b0 || dropped !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: out_nd=%b dropped=%b, required 0000/0", out_nd, dropped);
    end
  endtask

  task automatic test_single_packet();
    logic [31:0] w [4];
    w[0] = hdr(3, 2, 19'h00011);
    w[1] = 32'hC0DE_0001;
    w[2] = 32'h0000_0002;
    w[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (out_nd !== 4'b0) begin
          fails++;
          $display("FAIL single_latency: out_nd=%b one edge after input, required 0000", out_nd);
        end
      end else if (i >= 2) begin
        checks++;
        if (out_nd !== 4'b0100 || out_data !== w[i-2]) begin
          fails++;
          $display("FAIL single_word%0d: out_nd=%b out_data=%h, required 0100 %h",
                   i-2, out_nd, out_data, w[i-2]);
        end
      end
      if (i < 4) begin
        in_nd   = 1'b1;
        in_data = w[i];
      end else begin
        in_nd = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (out_nd !== 4'b0) begin
      fails++;
      $display("FAIL single_end: out_nd=%b after packet, required 0000", out_nd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    logic [3:0]  nd [3];
    w[0] = hdr(1, 0, 19'h00022); nd[0] = 4'b0001;
    w[1] = 32'h1234_ABCD;        nd[1] = 4'b0001;
    w[2] = hdr(0, 3, 19'h00033); nd[2] = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 4) begin
        checks++;
        if (out_nd !== nd[i-2] || out_data !== w[i-2] || dropped !== 1'b0) begin
          fails++;
          $display("FAIL b2b_word%0d: out_nd=%b out_data=%h dropped=%b, required %b %h 0",
                   i-2, out_nd, out_data, dropped, nd[i-2], w[i-2]);
        end
      end else if (i == 5) begin
        checks++;
        if (out_nd !== 4'b0) begin
          fails++;
          $display("FAIL b2b_end: out_nd=%b, required 0000", out_nd);
        end
      end
      if (i < 3) begin
        in_nd   = 1'b1;
        in_data = w[i];
      end else begin
        in_nd = 1'b0;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] w [5];
    int          exp_idx [13];
    w[0] = hdr(4, 1, 19'h00044);
    w[1] = 32'hA000_0001;
    w[2] = 32'h2000_0002;
    w[3] = 32'hA000_0003;
    w[4] = 32'h2000_0004;
    exp_idx = '{-1, -1, 0, 1, -1, -1, -1, -1, -1, 2, 3, 4, -1};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        checks++;
        if (exp_idx[i] < 0) begin
          if (out_nd !== 4'b0) begin
            fails++;
            $display("FAIL stall_cycle%0d: out_nd=%b, required 0000", i, out_nd);
          end
        end else if (out_nd !== 4'b0010 || out_data !== w[exp_idx[i]]) begin
          fails++;
          $display("FAIL stall_cycle%0d: out_nd=%b out_data=%h, required 0010 %h",
                   i, out_nd, out_data, w[exp_idx[i]]);
        end
      end
      if (i == 3) out_ready = 4'b1101;
      if (i == 8) out_ready = 4'b1111;
      if (i < 5) begin
        in_nd   = 1'b1;
        in_data = w[i];
      end else begin
        in_nd = 1'b0;
      end
    end
  endtask

  task automatic test_stray_word();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        checks++;
        if (dropped !== (i == 2) || out_nd !== 4'b0) begin
          fails++;
          $display("FAIL stray_cycle%0d: dropped=%b out_nd=%b, required %b 0000",
                   i, dropped, out_nd, (i == 2));
        end
      end
      if (i == 0) begin
        in_nd   = 1'b1;
        in_data = 32'h1234_5678;
      end else begin
        in_nd = 1'b0;
      end
    end
  endtask

  task automatic test_unroutable();
    logic [31:0] w [5];
    logic [2:0]  exp_nd;
    logic [31:0] exp_data;
    w[0] = hdr(2, 3, 19'h00055);
    w[1] = 32'hFFFF_FFFF;
    w[2] = 32'h8000_0000;
    w[3] = hdr(1, 1, 19'h00066);
    w[4] = 32'h0000_BEEF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        exp_nd   = (i == 5 || i == 6) ? 3'b010 : 3'b000;
        exp_data = (i == 5) ? w[3] : w[4];
        checks++;
        if (dropped3 !== (i == 2) || out_nd3 !== exp_nd ||
            (exp_nd != 3'b000 && out_data3 !== exp_data)) begin
          fails++;
          $display("FAIL unroutable_cycle%0d: dropped=%b out_nd=%b out_data=%h, required %b %b %h",
                   i, dropped3, out_nd3, out_data3, (i == 2), exp_nd, exp_data);
        end
      end
      if (i < 5) begin
        in_nd3  = 1'b1;
        in_data = w[i];
      end else begin
        in_nd3 = 1'b0;
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_data;
    out_ready = 4'b0000;
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      if (i == 64) begin
        checks++;
        if (error !== 1'b0 || out_nd !== 4'b0) begin
          fails++;
          $display("FAIL ovf_before: error=%b out_nd=%b with 64 words held, required 0 0000", error, out_nd);
        end
      end
      in_nd   = 1'b1;
      in_data = (i == 0) ? hdr(63, 0, 19'h00077) :
                (i == 64) ? 32'h0BAD_0BAD : 32'h5000_0000 + 32'(i);
    end
    @(negedge clk);
    in_nd = 1'b0;
    checks++;
    if (error !== 1'b1) begin
      fails++;
      $display("FAIL ovf_error: error=%b after 65th write, required 1", error);
    end
    out_ready = 4'b1111;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      exp_data = (i == 0) ? hdr(63, 0, 19'h00077) : 32'h5000_0000 + 32'(i);
      checks++;
      if (out_nd !== 4'b0001 || out_data !== exp_data) begin
        fails++;
        $display("FAIL ovf_word%0d: out_nd=%b out_data=%h, required 0001 %h",
                 i, out_nd, out_data, exp_data);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_nd !== 4'b0 || dropped !== 1'b0 || error !== 1'b1) begin
        fails++;
        $display("FAIL ovf_tail%0d: out_nd=%b dropped=%b error=%b, required 0000 0 1",
                 i, out_nd, dropped, error);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] w [3];
    w[0] = hdr(4, 2, 19'h00088);
    w[1] = 32'h7777_0001;
    w[2] = 32'h7777_0002;
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_nd   = 1'b1;
      in_data = w[i];
    end
    @(negedge clk);
    in_nd = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_nd !== 4'b0 || out_data !== 32'h0 || dropped !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: out_nd=%b out_data=%h dropped=%b error=%b, required 0000/00000000/0/0",
               out_nd, out_data, dropped, error);
    end
    rst_n   = 1'b1;
    in_nd   = 1'b1;
    in_data = hdr(0, 3, 19'h00099);
    @(negedge clk);
    in_nd = 1'b0;
    checks++;
    if (out_nd !== 4'b0 || dropped !== 1'b0) begin
      fails++;
      $display("FAIL midreset_gap: out_nd=%b dropped=%b, required 0000 0", out_nd, dropped);
    end
    @(negedge clk);
    checks++;
    if (out_nd !== 4'b1000 || out_data !== hdr(0, 3, 19'h00099) || dropped !== 1'b0) begin
      fails++;
      $display("FAIL midreset_route: out_nd=%b out_data=%h dropped=%b, required 1000 %h 0",
               out_nd, out_data, dropped, hdr(0, 3, 19'h00099));
    end
    @(negedge clk);
    checks++;
    if (out_nd !== 4'b0 || dropped !== 1'b0) begin
      fails++;
      $display("FAIL midreset_end: out_nd=%b dropped=%b, required 0000 0", out_nd, dropped);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_stall();
    test_stray_word();
    test_unroutable();
    test_overflow();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
